// File: rtl/mod_updown_counter.sv
// Up/down counter with runtime limit, parallel load, and three terminal modes.
// The modes are wrap, saturate and one-shot. The terminal-count pulse and the
// one-shot done flag are registered, so every output comes straight from a flop.
module mod_updown_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] limit,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             done
);

   localparam logic [1:0] MODE_WRAP    = 2'b00;
   localparam logic [1:0] MODE_SAT     = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] step_val;
   logic [WIDTH-1:0] term_val;
   logic             wrapped;
   logic             hit;
   logic             wrap_mode;

   // Mode 11 is reserved and behaves exactly like wrap.
   assign wrap_mode = (mode != MODE_SAT) && (mode != MODE_ONESHOT);

   // Value one enabled step would produce, ignoring load and done gating.
   always_comb begin
      step_val = count_q;
      wrapped  = 1'b0;
      if (up) begin
         if (count_q < limit) begin
            step_val = count_q + 1'b1;
         end else if (wrap_mode) begin
            step_val = '0;
            wrapped  = 1'b1;
         end else begin
            // Saturate and one-shot both clamp. This also pulls count back
            // into range when limit has been lowered below it.
            step_val = limit;
         end
      end else begin
         if (count_q > limit) begin
            step_val = limit;
         end else if (count_q != '0) begin
            step_val = count_q - 1'b1;
         end else if (wrap_mode) begin
            step_val = limit;
            wrapped  = 1'b1;
         end else begin
            step_val = '0;
         end
      end
   end

   // Terminal pulse: the step lands on the terminal value, either by moving
   // there or by wrapping back onto it. The second case only arises with limit = 0.
   assign term_val = up ? limit : '0;
   assign hit      = (step_val == term_val) && ((step_val != count_q) || wrapped);

   // Next-state selection with load taking priority over the enabled step.
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      done_d  = done_q;
      if (mode != MODE_ONESHOT) begin
         done_d = 1'b0;
      end
      if (load) begin
         count_d = (load_val <= limit) ? load_val : limit;
         done_d  = 1'b0;
      end else if (en && !done_q) begin
         count_d = step_val;
         tc_d    = hit;
         if (hit && (mode == MODE_ONESHOT)) begin
            done_d = 1'b1;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         done_q  <= done_d;
      end
   end

   assign count = count_q;
   assign tc    = tc_q;
   assign done  = done_q;

endmodule
